gpio_share_arbiter: RTL

Shares one group of user-project mprj_io output pins among NREQ team-level requesters. Only one requester drives the pins at a time.
- Grants rotate round-robin.
- A grant ends when its holder releases it, or is cut short at a hold limit when another requester is waiting.
- A forced turnaround gap with all pins tri-stated sits between owners, so two drivers never fight.
- The block sits between the team wrappers and the Caravel io_out/io_oeb pins.

---
 rtl/gpio_share_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gpio_share_arbiter.sv
// gpio_share_arbiter: round-robin owner of one shared group of mprj_io pins.
// One requester drives the pins at a time; a tri-stated turnaround gap
// always separates two different owners so the pads never see a fight.
module gpio_share_arbiter #(
    parameter int NREQ       = 4,
    parameter int W          = 8,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      en,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*W-1:0]         req_out,
    input  logic [NREQ*W-1:0]         req_oe,
    output logic [NREQ-1:0]           gnt,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic [W-1:0]              io_out,
    output logic [W-1:0]              io_oeb
);

    localparam int OW = $clog2(NREQ);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int TW = (TURNAROUND < 2) ? 1 : $clog2(TURNAROUND);

    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   turn_cnt;
    logic [OW-1:0]   pick;
    logic            others_waiting;
    logic            limit_hit;
    logic            any_req;

    // Nearest requester after 'last' in rotating order; 'last' itself is
    // considered only after every other index (distance NREQ).
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   last);
        logic [OW-1:0] p;
        int            best;
        int            d;
        p    = last;
        best = NREQ + 1;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - int'(last)) % NREQ;
            if (d == 0) d = NREQ;
            if (r[i] && d < best) begin
                best = d;
                p    = OW'(i);
            end
        end
        return p;
    endfunction

    assign pick           = rr_pick(req, owner);
    assign any_req        = |req;
    assign others_waiting = |(req & ~(NREQ'(1) << owner));
    // The counter saturates at MAX_HOLD, so ">=" lets a requester that
    // arrives after saturation still cut a long lone grant short.
    assign limit_hit      = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST) && others_waiting;
    assign busy           = (state != IDLE);

    // Arbitration FSM: grant, hold accounting and turnaround gap.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= OW'(NREQ - 1);
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && any_req) begin
                        state    <= GRANT;
                        gnt      <= NREQ'(1) << pick;
                        owner    <= pick;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
                    if (!req[owner] || !en || limit_hit) begin
                        state    <= TURN;
                        gnt      <= '0;
                        turn_cnt <= '0;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        if (en && any_req) begin
                            state    <= GRANT;
                            gnt      <= NREQ'(1) << pick;
                            owner    <= pick;
                            hold_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Pin mux: only the granted owner reaches the pads, otherwise tri-state.
    always_comb begin
        io_out = '0;
        io_oeb = '1;
        if (state == GRANT) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner == OW'(i)) begin
                    io_out = req_out[i*W +: W];
                    io_oeb = ~req_oe[i*W +: W];
                end
            end
        end
    end

endmodule
